// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_pkg: shared digit count, glyph patterns and blank-code limit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seven_seg_pkg;

  localparam int NUM_DIGITS     = 4;
  localparam int BLANK_CODE_MIN = 16;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_glyph_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_glyph_rom: 5-bit digit code to active-high segment pattern.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seven_seg_glyph_rom
  import seven_seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_pattern
);

  always_comb begin
    o_pattern = GLYPH_BLANK;
    if (i_code < 5'(BLANK_CODE_MIN)) begin
      case (i_code[3:0])
        4'h0:    o_pattern = GLYPH_0;
        4'h1:    o_pattern = GLYPH_1;
        4'h2:    o_pattern = GLYPH_2;
        4'h3:    o_pattern = GLYPH_3;
        4'h4:    o_pattern = GLYPH_4;
        4'h5:    o_pattern = GLYPH_5;
        4'h6:    o_pattern = GLYPH_6;
        4'h7:    o_pattern = GLYPH_7;
        4'h8:    o_pattern = GLYPH_8;
        4'h9:    o_pattern = GLYPH_9;
        4'hA:    o_pattern = GLYPH_A;
        4'hB:    o_pattern = GLYPH_B;
        4'hC:    o_pattern = GLYPH_C;
        4'hD:    o_pattern = GLYPH_D;
        4'hE:    o_pattern = GLYPH_E;
        default: o_pattern = GLYPH_F;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_scan_driver: 4-digit multiplexed 7-segment driver with frame-  |
// | coherent capture, leading-zero blanking and per-digit decimal points.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       blank_lz,
  input  logic [3:0] dp_mask,
  input  logic [4:0] digit0,
  input  logic [4:0] digit1,
  input  logic [4:0] digit2,
  input  logic [4:0] digit3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int C_PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int C_IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(REFRESH_DIV - 1);
  localparam logic [C_PRESC_W-1:0] C_PRESC_ONE = C_PRESC_W'(1);
  localparam logic [C_IDX_W-1:0]   C_IDX_LAST  = C_IDX_W'(NUM_DIGITS - 1);
  localparam logic [C_IDX_W-1:0]   C_IDX_ONE   = C_IDX_W'(1);

  localparam logic [6:0]            C_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  C_DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

  logic [C_PRESC_W-1:0]  r_presc;
  logic [C_IDX_W-1:0]    r_idx;
  logic [4:0]            r_shadow [NUM_DIGITS];
  logic                  r_load_pending;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_tick;

  logic [4:0]            w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:1] w_is_zero;
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic                  w_lz_run;
  logic                  w_slot_tick;
  logic                  w_frame_start;
  logic [4:0]            w_code;
  logic [6:0]            w_rom_pattern;
  logic [6:0]            w_pattern;
  logic [NUM_DIGITS-1:0] w_an_onehot;

  assign w_digit[0] = digit0;
  assign w_digit[1] = digit1;
  assign w_digit[2] = digit2;
  assign w_digit[3] = digit3;

  assign w_slot_tick   = (r_presc == C_PRESC_MAX);
  assign w_frame_start = w_slot_tick && (r_idx == C_IDX_LAST);

  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_zero
    assign w_is_zero[k] = (r_shadow[k] == 5'd0);
  end

  // A digit blanks only while every more-significant digit is also zero.
  always_comb begin
    w_lz_blank = '0;
    w_lz_run   = blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_lz_run      = w_lz_run & w_is_zero[k];
      w_lz_blank[k] = w_lz_run;
    end
  end

  assign w_code      = r_shadow[r_idx];
  assign w_pattern   = w_lz_blank[r_idx] ? GLYPH_BLANK : w_rom_pattern;
  assign w_an_onehot = digit_onehot(r_idx);

  seven_seg_glyph_rom u_glyph_rom (
    .i_code    (w_code),
    .o_pattern (w_rom_pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc        <= '0;
      r_idx          <= '0;
      r_load_pending <= 1'b1;
      r_an           <= C_AN_OFF;
      r_seg          <= C_SEG_OFF;
      r_dp           <= C_DP_OFF;
      r_frame_tick   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= 5'd0;
      end
    end else if (!enable) begin
      // Shadow and load_pending are kept so the display resumes unchanged.
      r_presc      <= '0;
      r_idx        <= '0;
      r_an         <= C_AN_OFF;
      r_seg        <= C_SEG_OFF;
      r_dp         <= C_DP_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc        <= w_slot_tick ? '0 : r_presc + C_PRESC_ONE;
      r_frame_tick   <= w_frame_start;
      r_load_pending <= 1'b0;
      if (w_slot_tick) begin
        r_idx <= r_idx + C_IDX_ONE;
      end
      if (w_frame_start || r_load_pending) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          r_shadow[i] <= w_digit[i];
        end
      end
      r_an  <= AN_ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;
      r_seg <= SEG_ACTIVE_LOW ? ~w_pattern : w_pattern;
      r_dp  <= SEG_ACTIVE_LOW ? ~dp_mask[r_idx] : dp_mask[r_idx];
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seven_seg_scan_driver: directed self-checking bench, REFRESH_DIV=4.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seven_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       blank_lz;
  logic [3:0] dp_mask;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [4:0] a3, input logic [4:0] a2,
                            input logic [4:0] a1, input logic [4:0] a0);
    digit3 = a3;
    digit2 = a2;
    digit1 = a1;
    digit0 = a0;
  endtask

  // Leaves the bench just after the edge on which frame_tick rose.
  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (frame_tick === 1'b1) found = 1'b1;
    end
    chk("frame_wait", {31'b0, found}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    set_digits(5'd0, 5'd0, 5'd0, 5'd0);
    tick(2);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_ft", frame_tick, 1'b0);

    // Basic scan of 1,2,3,4
    set_digits(5'd1, 5'd2, 5'd3, 5'd4);
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);
    chk("scan_an0_first", an, 4'hE);
    chk("scan_load_no_ft", frame_tick, 1'b0);
    tick(1);
    chk("scan_seg0", seg, 7'h19);
    tick(3);
    chk("scan_an1", an, 4'hD);
    chk("scan_seg1", seg, 7'h30);
    tick(4);
    chk("scan_an2", an, 4'hB);
    chk("scan_seg2", seg, 7'h24);
    tick(4);
    chk("scan_an3", an, 4'h7);
    chk("scan_seg3", seg, 7'h79);
    tick(2);
    chk("scan_ft_low", frame_tick, 1'b0);
    tick(1);
    chk("scan_ft16", frame_tick, 1'b1);
    tick(1);
    chk("scan_ft_pulse", frame_tick, 1'b0);
    chk("scan_wrap_an0", an, 4'hE);
    tick(15);
    chk("scan_ft32", frame_tick, 1'b1);

    // Mid-frame change must not tear the current frame
    wait_frame();
    tick(10);
    digit0 = 5'd9;
    digit3 = 5'd8;
    tick(4);
    chk("tear_an3", an, 4'h7);
    chk("tear_seg3_old", seg, 7'h79);
    wait_frame();
    tick(2);
    chk("tear_an0_new", an, 4'hE);
    chk("tear_seg0_new", seg, 7'h10);
    tick(12);
    chk("tear_seg3_new", seg, 7'h00);

    // Leading-zero blanking
    set_digits(5'd0, 5'd0, 5'd0, 5'd7);
    blank_lz = 1'b1;
    wait_frame();
    tick(2);
    chk("lz_seg0", seg, 7'h78);
    tick(4);
    chk("lz_an1", an, 4'hD);
    chk("lz_seg1", seg, 7'h7F);
    tick(4);
    chk("lz_seg2", seg, 7'h7F);
    tick(4);
    chk("lz_an3", an, 4'h7);
    chk("lz_seg3", seg, 7'h7F);

    set_digits(5'd0, 5'd5, 5'd0, 5'd0);
    wait_frame();
    tick(2);
    chk("lz2_seg0", seg, 7'h40);
    tick(4);
    chk("lz2_seg1", seg, 7'h40);
    tick(4);
    chk("lz2_seg2", seg, 7'h12);
    tick(4);
    chk("lz2_seg3", seg, 7'h7F);

    // Out-of-range and hex codes, decimal points on
    blank_lz = 1'b0;
    dp_mask  = 4'hF;
    set_digits(5'd0, 5'd11, 5'd20, 5'd0);
    wait_frame();
    tick(6);
    chk("oor_seg1", seg, 7'h7F);
    tick(4);
    chk("hex_b_seg2", seg, 7'h03);
    chk("dp_lit", dp, 1'b0);

    // Disable mid-slot, then re-enable
    tick(1);
    enable = 1'b0;
    digit0 = 5'd3;
    tick(1);
    chk("dis_an", an, 4'hF);
    chk("dis_seg", seg, 7'h7F);
    chk("dis_dp", dp, 1'b1);
    tick(5);
    chk("dis_hold_an", an, 4'hF);
    chk("dis_no_ft", frame_tick, 1'b0);
    enable = 1'b1;
    tick(1);
    chk("reen_an0", an, 4'hE);
    tick(1);
    chk("reen_shadow_kept", seg, 7'h40);
    cnt = 2;
    while (cnt < 40 && frame_tick !== 1'b1) begin
      tick(1);
      cnt++;
    end
    chk("reen_ft_cycles", cnt, 32'd16);

    // Reset during slot 3, then direct load on first enabled cycle
    set_digits(5'd1, 5'd2, 5'd3, 5'd4);
    dp_mask = 4'b1000;
    wait_frame();
    tick(14);
    chk("rst_pre_an3", an, 4'h7);
    chk("rst_pre_dp3", dp, 1'b0);
    reset = 1'b1;
    tick(1);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_ft", frame_tick, 1'b0);
    reset = 1'b0;
    tick(1);
    chk("post_an0", an, 4'hE);
    chk("post_dp0_off", dp, 1'b1);
    chk("post_no_ft", frame_tick, 1'b0);
    tick(1);
    chk("post_seg0_loaded", seg, 7'h19);
    tick(12);
    chk("post_an3", an, 4'h7);
    chk("post_dp3_on", dp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
